// File: rtl/snes_pad_responder.sv
// snes_pad_responder: device side of the SNES controller serial link.
// Watches the host latch/clock lines and shifts a 16-bit, active-low
// button word out on serial_data the way a physical pad does.
// Optional feature macro: PAD_TURBO_EN (adds turbo_mask and a turbo phase).
module snes_pad_responder #(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd560000,
  parameter int          TURBO_FRAMES   = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        data_latch,
  input  logic        data_clock,
  input  logic [15:0] buttons_in,
`ifdef PAD_TURBO_EN
  input  logic [15:0] turbo_mask,
`endif
  output logic        serial_data,
  output logic        busy,
  output logic        idle,
  output logic        overrun,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [SYNC_STAGES-1:0] latch_sync, clock_sync;
  logic        latch_q, clock_q;
  logic        latch_s, clock_s;
  logic        latch_rise, latch_fall, clock_rise;
  logic [15:0] shreg, shreg_nxt, load_word;
  logic [4:0]  bit_cnt;
  logic [19:0] tmo_cnt;
  logic        load, shift_en, tmo_hit, serial_nxt;

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clock_s    = clock_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_q;
  assign latch_fall = ~latch_s & latch_q;
  assign clock_rise = clock_s & ~clock_q;
  assign busy       = (state == S_SHIFT);

  // Synchronize host lines and keep one extra flop for edge detection.
  // The clock chain resets high (line idles high) so release of reset
  // never looks like a clock rising edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      latch_sync <= '0;
      clock_sync <= '1;
      latch_q    <= 1'b0;
      clock_q    <= 1'b1;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], data_latch};
      clock_sync <= {clock_sync[SYNC_STAGES-2:0], data_clock};
      latch_q    <= latch_s;
      clock_q    <= clock_s;
    end
  end

`ifdef PAD_TURBO_EN
  localparam int TW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  logic          phase;
  logic [TW-1:0] turbo_cnt;

  // Turbo buttons read as pressed only during phase 1; phase flips after
  // every TURBO_FRAMES latches, using the phase held before this latch.
  assign load_word = {4'hF, ~(buttons_in[11:0] & ~(turbo_mask[11:0] & {12{~phase}}))};

  // Count latches to advance the turbo phase.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      phase     <= 1'b0;
      turbo_cnt <= '0;
    end else if (load) begin
      if (turbo_cnt == TW'(TURBO_FRAMES - 1)) begin
        turbo_cnt <= '0;
        phase     <= ~phase;
      end else begin
        turbo_cnt <= turbo_cnt + TW'(1);
      end
    end
  end
`else
  // Bits 12-15 always read as released.
  assign load_word = {4'hF, ~buttons_in[11:0]};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath controls; latch edges win over everything,
  // including a clock edge seen in the same cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    tmo_hit   = (tmo_cnt == TIMEOUT_CYCLES - 20'd1);
    if (latch_rise) begin
      load      = 1'b1;
      state_nxt = S_LATCH;
    end else if (tmo_hit) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_LATCH: if (latch_fall) state_nxt = S_SHIFT;
        S_SHIFT: if (clock_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd15) state_nxt = S_DONE;
        end
        default: ;
      endcase
    end
    shreg_nxt = shreg;
    if (load)          shreg_nxt = load_word;
    else if (shift_en) shreg_nxt = {1'b0, shreg[15:1]};
    case (state_nxt)
      S_IDLE:  serial_nxt = 1'b1;
      S_DONE:  serial_nxt = 1'b0;
      default: serial_nxt = shreg_nxt[0];
    endcase
  end

  // Shift register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shreg       <= '1;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      frame_cnt   <= '0;
      idle        <= 1'b1;
      overrun     <= 1'b0;
      serial_data <= 1'b1;
    end else begin
      shreg       <= shreg_nxt;
      serial_data <= serial_nxt;
      overrun     <= load && (state == S_SHIFT);
      if (load) begin
        bit_cnt   <= '0;
        tmo_cnt   <= '0;
        frame_cnt <= frame_cnt + 8'd1;
        idle      <= 1'b0;
      end else begin
        if (shift_en) bit_cnt <= bit_cnt + 5'd1;
        if (tmo_cnt != TIMEOUT_CYCLES) tmo_cnt <= tmo_cnt + 20'd1;
        if (tmo_hit) idle <= 1'b1;
      end
    end
  end

endmodule
